gate_eval_arbiter: RTL and testbench

//   Shares one registered (a|b)&c evaluation stage among NUM_REQ requesters.
//   A round-robin arbiter accepts one operand triple {a,b,c}, evaluates it in a
//   one-cycle registered stage, and returns the result with the requester id.
//   The response uses a valid/ready handshake. Sits between operand sources and
//   the consumer of the gate result.

---
 rtl/gate_eval_arbiter.sv | 105 ++++++++++
 tb/tb_gate_eval_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_eval_arbiter.sv
// Round-robin arbiter sharing one registered (a|b)&c evaluation stage among
// NUM_REQ requesters; results return with the requester id over valid/ready.
module gate_eval_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [NUM_REQ-1:0] req_a,
   input  logic [NUM_REQ-1:0] req_b,
   input  logic [NUM_REQ-1:0] req_c,
   output logic [NUM_REQ-1:0] req_ready,
   output logic               rsp_valid,
   output logic               rsp_d,
   output logic [ID_W-1:0]    rsp_id,
   input  logic               rsp_ready,
   output logic               busy,
   output logic [CNT_W-1:0]   done_cnt
);

   typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

   state_t            state, state_nxt;
   logic [ID_W-1:0]   ptr;
   logic [ID_W-1:0]   win_id;
   logic              win_vld;
   logic              accept_win;
   logic              accept;
   logic              a_p0, b_p0, c_p0;

   function automatic logic gate_eval(input logic a, input logic b, input logic c);
      return (a | b) & c;
   endfunction

   function automatic logic [CNT_W-1:0] cnt_wrap_inc(input logic [CNT_W-1:0] v);
      return v + 1'b1;
   endfunction

   // Search starts one past the last winner, so the previous winner is lowest.
   always_comb begin
      int idx;
      idx     = 0;
      win_vld = 1'b0;
      win_id  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!win_vld && req_valid[idx]) begin
            win_vld = 1'b1;
            win_id  = ID_W'(idx);
         end
      end
   end

   assign accept_win = rst_n && ((state == IDLE) || ((state == RESP) && rsp_ready));
   assign accept     = accept_win && win_vld;

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[win_id] = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = EVAL;
         EVAL:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = accept ? EVAL : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Stage p0: operands of the winner captured at accept
   always_ff @(posedge clk) begin
      if (accept) begin
         a_p0 <= req_a[win_id];
         b_p0 <= req_b[win_id];
         c_p0 <= req_c[win_id];
      end
   end

   // Stage p1: evaluated result, control and completion count
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= ID_W'(NUM_REQ - 1);
         rsp_d    <= 1'b0;
         rsp_id   <= '0;
         done_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            ptr    <= win_id;
            rsp_id <= win_id;
         end
         if (state == EVAL) rsp_d <= gate_eval(a_p0, b_p0, c_p0);
         if ((state == RESP) && rsp_ready) done_cnt <= cnt_wrap_inc(done_cnt);
      end
   end

   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_gate_eval_arbiter.sv
// Directed bench for gate_eval_arbiter; a second instance with a 4-bit
// counter shares all inputs to exercise done_cnt wrap.
module tb_gate_eval_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req_valid, req_a, req_b, req_c;
   logic [3:0] req_ready, req_ready4;
   logic       rsp_valid, rsp_valid4;
   logic       rsp_d, rsp_d4;
   logic [1:0] rsp_id, rsp_id4;
   logic       rsp_ready;
   logic       busy, busy4;
   logic [15:0] done_cnt;
   logic [3:0]  done_cnt4;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   gate_eval_arbiter #(.NUM_REQ(4), .ID_W(2), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a),
      .req_b(req_b), .req_c(req_c), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_d(rsp_d), .rsp_id(rsp_id),
      .rsp_ready(rsp_ready), .busy(busy), .done_cnt(done_cnt)
   );

   gate_eval_arbiter #(.NUM_REQ(4), .ID_W(2), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a),
      .req_b(req_b), .req_c(req_c), .req_ready(req_ready4),
      .rsp_valid(rsp_valid4), .rsp_d(rsp_d4), .rsp_id(rsp_id4),
      .rsp_ready(rsp_ready), .busy(busy4), .done_cnt(done_cnt4)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 4'hF; req_a = 4'hF; req_b = 4'h0; req_c = 4'hF;
      rsp_ready = 1'b0;
      settle();
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_req_ready cyc%0d got %b want 0000", i, req_ready);
         end
         step();
      end
      n_checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || done_cnt !== 16'd0 || rsp_d !== 1'b0 || rsp_id !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_state got v=%b busy=%b cnt=%0d d=%b id=%0d want 0 0 0 0 0",
                  rsp_valid, busy, done_cnt, rsp_d, rsp_id);
      end
      req_valid = 4'h0;
      rst_n = 1'b1;
      settle();
   endtask

   task automatic single_req(input logic a, input logic b, input logic c, input logic exp_d,
                             input int exp_cnt);
      req_valid = 4'b0010; req_a = {2'b00, a, 1'b0}; req_b = {2'b00, b, 1'b0};
      req_c = {2'b00, c, 1'b0}; rsp_ready = 1'b0;
      settle();
      n_checks++;
      if (req_ready !== 4'b0010) begin
         n_fail++; $display("FAIL single_grant got %b want 0010", req_ready);
      end
      step();
      req_valid = 4'h0;
      settle();
      n_checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL single_eval got v=%b busy=%b want 0 1", rsp_valid, busy);
      end
      step();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_d !== exp_d || rsp_id !== 2'd1) begin
         n_fail++;
         $display("FAIL single_resp got v=%b d=%b id=%0d want 1 %b 1", rsp_valid, rsp_d, rsp_id, exp_d);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || done_cnt !== 16'(exp_cnt)) begin
         n_fail++;
         $display("FAIL single_done got busy=%b v=%b cnt=%0d want 0 0 %0d", busy, rsp_valid, done_cnt, exp_cnt);
      end
   endtask

   task automatic test_single();
      single_req(1'b1, 1'b0, 1'b1, 1'b1, 1);
      single_req(1'b0, 1'b0, 1'b1, 1'b0, 2);
   endtask

   task automatic test_back_to_back();
      logic [3:0] a_pat;
      logic [3:0] exp_oh;
      logic [1:0] exp_id;
      test_reset();
      a_pat = 4'b0101;
      req_valid = 4'hF; req_a = a_pat; req_b = 4'h0; req_c = 4'hF; rsp_ready = 1'b1;
      settle();
      for (int k = 0; k < 5; k++) begin
         exp_oh = 4'b0001 << (k % 4);
         n_checks++;
         if (req_ready !== exp_oh) begin
            n_fail++; $display("FAIL b2b_grant k=%0d got %b want %b", k, req_ready, exp_oh);
         end
         if (k > 0) begin
            n_checks++;
            if (done_cnt !== 16'(k - 1)) begin
               n_fail++; $display("FAIL b2b_cnt_pre k=%0d got %0d want %0d", k, done_cnt, k - 1);
            end
         end
         step();
         n_checks++;
         if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL b2b_eval k=%0d got v=%b rdy=%b want 0 0000", k, rsp_valid, req_ready);
         end
         step();
         exp_id = 2'(k % 4);
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_d !== a_pat[exp_id]) begin
            n_fail++;
            $display("FAIL b2b_resp k=%0d got v=%b id=%0d d=%b want 1 %0d %b",
                     k, rsp_valid, rsp_id, rsp_d, exp_id, a_pat[exp_id]);
         end
      end
      req_valid = 4'h0;
      step();
      rsp_ready = 1'b0;
      n_checks++;
      if (done_cnt !== 16'd5 || busy !== 1'b0) begin
         n_fail++; $display("FAIL b2b_cnt got cnt=%0d busy=%b want 5 0", done_cnt, busy);
      end
   endtask

   task automatic test_backpressure();
      test_reset();
      req_valid = 4'b0001; req_a = 4'b0001; req_b = 4'h0; req_c = 4'b0001; rsp_ready = 1'b0;
      step();
      req_valid = 4'h0;
      step();
      req_valid = 4'hF; req_a = 4'h0; req_c = 4'h0;
      for (int i = 0; i < 5; i++) begin
         settle();
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_d !== 1'b1 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_hold cyc%0d got v=%b d=%b id=%0d rdy=%b want 1 1 0 0000",
                     i, rsp_valid, rsp_d, rsp_id, req_ready);
         end
         step();
      end
      req_valid = 4'b0100; req_a = 4'b0000; req_b = 4'b0100; req_c = 4'b0100; rsp_ready = 1'b1;
      settle();
      n_checks++;
      if (req_ready !== 4'b0100) begin
         n_fail++; $display("FAIL bp_release_grant got %b want 0100", req_ready);
      end
      step();
      req_valid = 4'h0;
      settle();
      n_checks++;
      if (busy !== 1'b1 || rsp_valid !== 1'b0 || done_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL bp_eval got busy=%b v=%b cnt=%0d want 1 0 1", busy, rsp_valid, done_cnt);
      end
      step();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_d !== 1'b1) begin
         n_fail++; $display("FAIL bp_resp2 got v=%b id=%0d d=%b want 1 2 1", rsp_valid, rsp_id, rsp_d);
      end
      step();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_in_eval();
      test_reset();
      req_valid = 4'b0010; req_a = 4'b0010; req_b = 4'h0; req_c = 4'b0010; rsp_ready = 1'b0;
      step();
      req_valid = 4'h0;
      rst_n = 1'b0;
      settle();
      n_checks++;
      if (busy !== 1'b1 || req_ready !== 4'b0000) begin
         n_fail++; $display("FAIL rst_eval_pre got busy=%b rdy=%b want 1 0000", busy, req_ready);
      end
      step();
      rst_n = 1'b1;
      settle();
      n_checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_eval_idle got busy=%b v=%b want 0 0", busy, rsp_valid);
      end
      step();
      n_checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL rst_eval_nopulse got v=%b busy=%b want 0 0", rsp_valid, busy);
      end
      req_valid = 4'hF; req_a = 4'hF; req_c = 4'hF;
      settle();
      n_checks++;
      if (req_ready !== 4'b0001) begin
         n_fail++; $display("FAIL rst_eval_ptr got %b want 0001", req_ready);
      end
      step();
      req_valid = 4'h0;
      step();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
         n_fail++; $display("FAIL rst_eval_resp got v=%b id=%0d want 1 0", rsp_valid, rsp_id);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   task automatic test_cnt_wrap();
      test_reset();
      req_a = 4'b0001; req_b = 4'h0; req_c = 4'b0001; rsp_ready = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         req_valid = 4'b0001;
         step();
         req_valid = 4'h0;
         step();
         step();
         n_checks++;
         if (done_cnt4 !== 4'(i % 16) || done_cnt !== 16'(i)) begin
            n_fail++;
            $display("FAIL cnt_wrap i=%0d got cnt4=%0d cnt16=%0d want %0d %0d",
                     i, done_cnt4, done_cnt, i % 16, i);
         end
      end
      rsp_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_reset_in_eval();
      test_cnt_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
